bus_mem_responder: RTL and testbench

Data-memory responder for the RV32I core's data bus. It completes the load/store transactions the core initiates: it captures a request, inserts a configurable number of wait states, then writes byte lanes or returns sign/zero-extended read data with a one-cycle ready pulse. It flags misaligned and out-of-range accesses as errors. It sits between the core's bus master port and on-chip data RAM.

---
 rtl/bus_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_bus_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Data-memory responder for the RV32I data bus: captures one load/store, waits WAIT_STATES
// cycles, then pulses busReady with registered read data / error status.
module bus_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [2:0]  busSize,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Fields of the access being answered: live inputs when RESP follows capture directly.
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [2:0]  acc_size;
    logic        acc_err;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign acc_we   = (state_q == IDLE) ? busWe   : we_q;
    assign acc_addr = (state_q == IDLE) ? busAddr : addr_q;
    assign acc_size = (state_q == IDLE) ? busSize : size_q;

    always_comb begin
        logic illegal, misaligned, out_of_range;
        illegal      = (acc_size == 3'b011) || (acc_size == 3'b110) || (acc_size == 3'b111)
                       || (acc_we && acc_size[2]);
        misaligned   = ((acc_size[1:0] == 2'b01) && acc_addr[0])
                       || ((acc_size == 3'b010) && (acc_addr[1:0] != 2'b00));
        out_of_range = |acc_addr[31:AW+2];
        acc_err      = illegal || misaligned || out_of_range;
    end

    always_comb begin
        rd_word = mem[acc_addr[AW+1:2]];
        rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
        rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_size)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (busReq) begin
                    we_d    = busWe;
                    addr_d  = busAddr;
                    wdata_d = busWData;
                    size_d  = busSize;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            ready_d = 1'b1;
            err_d   = acc_err;
            rdata_d = (!acc_we && !acc_err) ? load_data : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 3'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Store commits on the edge leaving RESP; err_q already reflects the latched access.
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    assign wr_en = reset && (state_q == RESP) && we_q && !err_q;

    always_comb begin
        case (size_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign busReady = ready_q;
    assign busErr   = err_q;
    assign busRData = rdata_q;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_bus_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;

    logic [31:0] rdata1, rdata0;
    logic        rdy1, rdy0, err1, err0;
    logic [31:0] rdata;
    logic        rdy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset(reset), .busReq(req & sel), .busWe(we), .busAddr(addr),
        .busWData(wdata), .busSize(size), .busRData(rdata1), .busReady(rdy1), .busErr(err1)
    );

    bus_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .busReq(req & ~sel), .busWe(we), .busAddr(addr),
        .busWData(wdata), .busSize(size), .busRData(rdata0), .busReady(rdy0), .busErr(err0)
    );

    assign rdata = sel ? rdata1 : rdata0;
    assign rdy   = sel ? rdy1   : rdy0;
    assign err   = sel ? err1   : err0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] z, input logic [31:0] er, input logic ee);
        vec_t v;
        v.sel = s; v.we = w; v.addr = a; v.wdata = d; v.size = z;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the IDLE cycle after RESP.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] z, output logic [31:0] rd, output logic e,
                          output int lat);
        we = w; addr = a; wdata = d; size = z; req = 1'b1;
        lat = 0; rd = 32'd0; e = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (rdy) begin
                lat = i; rd = rdata; e = err;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("ready_one_cycle", {31'd0, rdy}, 32'd0);
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic        pat [7];

        add(1, 1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0);
        add(1, 0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0);
        add(1, 1, 32'h13,  32'hFFFFFF5A, 3'b000, 32'h0,        0);
        add(1, 0, 32'h13,  32'h0,        3'b000, 32'h0000005A, 0);
        add(1, 0, 32'h10,  32'h0,        3'b010, 32'h5AADBEEF, 0);
        add(1, 0, 32'h10,  32'h0,        3'b000, 32'hFFFFFFEF, 0);
        add(1, 0, 32'h10,  32'h0,        3'b100, 32'h000000EF, 0);
        add(1, 0, 32'h12,  32'h0,        3'b001, 32'h00005AAD, 0);
        add(1, 0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 0);
        add(1, 1, 32'h12,  32'h11111111, 3'b010, 32'h0,        1);
        add(1, 0, 32'h400, 32'h0,        3'b010, 32'h0,        1);
        add(1, 0, 32'h10,  32'h0,        3'b010, 32'h5AADBEEF, 0);
        add(1, 1, 32'h11,  32'h00000080, 3'b000, 32'h0,        0);
        add(1, 0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 0);
        add(1, 1, 32'h16,  32'h00008001, 3'b001, 32'h0,        0);
        add(1, 0, 32'h16,  32'h0,        3'b001, 32'hFFFF8001, 0);
        add(1, 0, 32'h16,  32'h0,        3'b101, 32'h00008001, 0);
        add(1, 0, 32'h11,  32'h0,        3'b001, 32'h0,        1);
        add(1, 0, 32'h10,  32'h0,        3'b011, 32'h0,        1);
        add(1, 0, 32'h10,  32'h0,        3'b110, 32'h0,        1);
        add(1, 1, 32'h10,  32'h00000000, 3'b100, 32'h0,        1);
        add(1, 0, 32'h10,  32'h0,        3'b010, 32'h5AAD80EF, 0);
        add(1, 1, 32'h3FC, 32'h01020304, 3'b010, 32'h0,        0);
        add(1, 0, 32'h3FC, 32'h0,        3'b010, 32'h01020304, 0);
        add(1, 0, 32'h3FF, 32'h0,        3'b000, 32'h00000001, 0);
        add(1, 1, 32'h20,  32'hCAFEF00D, 3'b010, 32'h0,        0);
        add(0, 1, 32'h40,  32'h11223344, 3'b010, 32'h0,        0);
        add(0, 0, 32'h41,  32'h0,        3'b000, 32'h00000033, 0);
        add(0, 0, 32'h42,  32'h0,        3'b101, 32'h00001122, 0);

        reset = 1'b0; req = 1'b0; sel = 1'b1;
        we = 1'b0; addr = 32'd0; wdata = 32'd0; size = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready1", {31'd0, rdy1}, 32'd0);
        check("rst_err1",   {31'd0, err1}, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_ready0", {31'd0, rdy0}, 32'd0);
        check("rst_err0",   {31'd0, err0}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, e, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].sel ? 32'd2 : 32'd1);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // WAIT_STATES=0 with busReq held: ready on every second cycle.
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        sel = 1'b0; we = 1'b0; addr = 32'h40; size = 3'b010; req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_ready%0d", i), {31'd0, rdy}, {31'd0, pat[i]});
            check($sformatf("b2b_rdata%0d", i), rdata, pat[i] ? 32'h11223344 : 32'd0);
            if (i == 4) req = 1'b0;
        end

        // Reset during WAIT aborts the store.
        sel = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; size = 3'b010; req = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_ready%0d", i), {31'd0, rdy}, 32'd0);
            @(posedge clk);
            #1;
        end
        access(1'b0, 32'h20, 32'h0, 3'b010, rd, e, lat);
        check("abort_load", rd, 32'hCAFEF00D);
        check("abort_load_err", {31'd0, e}, 32'd0);

        // Reset coinciding with a request: nothing captured.
        we = 1'b0; addr = 32'h20; size = 3'b010; req = 1'b1; reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1; req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_req_ready%0d", i), {31'd0, rdy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
